// File: rtl/dmem_pkg.sv
// Shared constants and helpers for the memory-stage data access unit.
// Covers func3 codes, FSM encoding, byte masks and access legality.
package dmem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [2:0] F3_WU = 3'b110;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [7:0] MASK_B = 8'h01;
   localparam logic [7:0] MASK_H = 8'h03;
   localparam logic [7:0] MASK_W = 8'h0F;
   localparam logic [7:0] MASK_D = 8'hFF;

   function automatic logic access_ok(
      input logic       is_store,
      input logic [2:0] f3,
      input logic [2:0] off
   );
      logic ok;
      unique case (f3[1:0])
         2'd0:    ok = 1'b1;
         2'd1:    ok = ~off[0];
         2'd2:    ok = (off[1:0] == 2'd0);
         default: ok = (off == 3'd0);
      endcase
      // 111 is never legal; stores have no unsigned variants
      if (f3 == 3'b111 || (is_store && f3[2])) ok = 1'b0;
      return ok;
   endfunction

   function automatic logic [7:0] byte_mask(input logic [1:0] sz);
      unique case (sz)
         2'd0:    return MASK_B;
         2'd1:    return MASK_H;
         2'd2:    return MASK_W;
         default: return MASK_D;
      endcase
   endfunction

   function automatic logic [63:0] lane_repl(
      input logic [1:0]  sz,
      input logic [63:0] d
   );
      unique case (sz)
         2'd0:    return {8{d[7:0]}};
         2'd1:    return {4{d[15:0]}};
         2'd2:    return {2{d[31:0]}};
         default: return d;
      endcase
   endfunction

endpackage

// File: rtl/dmem_access_unit_if.sv
// Pipeline-side request/response and RAM bus of the data access unit.
// master: pipeline and RAM model; slave: the access unit itself.
interface dmem_access_unit_if #(
   parameter int ADDR_W = 16
);
   logic              req_re;
   logic              req_we;
   logic [63:0]       req_addr;
   logic [63:0]       req_wdata;
   logic [2:0]        req_func3;
   logic              mem_stall;
   logic [63:0]       load_data;
   logic              misaligned;
   logic              ram_en;
   logic [7:0]        ram_we;
   logic [ADDR_W-4:0] ram_addr;
   logic [63:0]       ram_wdata;
   logic [63:0]       ram_rdata;

   modport master (
      output req_re, req_we, req_addr, req_wdata, req_func3, ram_rdata,
      input  mem_stall, load_data, misaligned,
      input  ram_en, ram_we, ram_addr, ram_wdata
   );

   modport slave (
      input  req_re, req_we, req_addr, req_wdata, req_func3, ram_rdata,
      output mem_stall, load_data, misaligned,
      output ram_en, ram_we, ram_addr, ram_wdata
   );
endinterface

// File: rtl/dmem_load_align.sv
// Load data formatter: lane shift by byte offset, then sign/zero extend.
// LD and any unlisted func3 pass the shifted word through.
module dmem_load_align
   import dmem_pkg::*;
(
   input  logic [63:0] rdata,
   input  logic [2:0]  offset,
   input  logic [2:0]  func3,
   output logic [63:0] load_data
);
   logic [63:0] sh;

   always_comb begin
      sh = rdata >> {offset, 3'b000};
      load_data = sh;
      case (func3)
         F3_B:    load_data = {{56{sh[7]}}, sh[7:0]};
         F3_H:    load_data = {{48{sh[15]}}, sh[15:0]};
         F3_W:    load_data = {{32{sh[31]}}, sh[31:0]};
         F3_BU:   load_data = {56'd0, sh[7:0]};
         F3_HU:   load_data = {48'd0, sh[15:0]};
         F3_WU:   load_data = {32'd0, sh[31:0]};
         default: load_data = sh;
      endcase
   end
endmodule

// File: rtl/dmem_access_unit.sv
// Memory-stage load/store controller with byte lanes and load stall FSM.
// Stores finish in one cycle; loads stall READ_LAT+1 cycles.
module dmem_access_unit
   import dmem_pkg::*;
#(
   parameter int ADDR_W   = 16,
   parameter int READ_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   dmem_access_unit_if.slave bus
);
   localparam logic [1:0] CNT_INIT = 2'(READ_LAT - 1);

   logic [1:0]        state_q, state_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [2:0]        off_q, off_d;
   logic [2:0]        f3_q, f3_d;
   logic [ADDR_W-4:0] addr_q, addr_d;
   logic [63:0]       load_q, load_d;
   logic [63:0]       aligned;

   logic              is_st, is_ld, ok;
   logic [2:0]        off;
   logic [ADDR_W-4:0] req_word;

   dmem_load_align u_align (
      .rdata     (bus.ram_rdata),
      .offset    (off_q),
      .func3     (f3_q),
      .load_data (aligned)
   );

   // store wins when both request lines are set
   assign is_st    = bus.req_we;
   assign is_ld    = bus.req_re & ~bus.req_we;
   assign off      = bus.req_addr[2:0];
   assign req_word = bus.req_addr[ADDR_W-1:3];
   assign ok       = access_ok(is_st, bus.req_func3, off);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      off_d   = off_q;
      f3_d    = f3_q;
      addr_d  = addr_q;
      load_d  = load_q;
      bus.mem_stall  = 1'b0;
      bus.misaligned = 1'b0;
      bus.ram_en     = 1'b0;
      bus.ram_we     = '0;
      bus.ram_addr   = '0;
      bus.ram_wdata  = '0;
      case (state_q)
         S_IDLE: begin
            if (is_st || is_ld) begin
               if (!ok) begin
                  bus.misaligned = 1'b1;
               end else if (is_st) begin
                  bus.ram_en    = 1'b1;
                  bus.ram_addr  = req_word;
                  bus.ram_we    = byte_mask(bus.req_func3[1:0]) << off;
                  bus.ram_wdata = lane_repl(bus.req_func3[1:0],
                                            bus.req_wdata);
               end else begin
                  bus.ram_en    = 1'b1;
                  bus.ram_addr  = req_word;
                  bus.mem_stall = 1'b1;
                  state_d = S_WAIT;
                  cnt_d   = CNT_INIT;
                  off_d   = off;
                  f3_d    = bus.req_func3;
                  addr_d  = req_word;
               end
            end
         end
         S_WAIT: begin
            bus.ram_en    = 1'b1;
            bus.ram_addr  = addr_q;
            bus.mem_stall = 1'b1;
            if (cnt_q == 2'd0) begin
               load_d  = aligned;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         // the still-held request must not be reissued here
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.load_data = load_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         off_q   <= '0;
         f3_q    <= '0;
         addr_q  <= '0;
         load_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         off_q   <= off_d;
         f3_q    <= f3_d;
         addr_q  <= addr_d;
         load_q  <= load_d;
      end
   end
endmodule
